display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares a single 4-bit hex-to-7-segment decoder between `DIGITS` digit positions. It cycles the active-low anode selects and feeds the decoder the selected nibble, with a blanking guard interval at every digit change to suppress ghosting. It sits between the numeric-value producers (counters, register readback) and the board's segment/anode pins.

## Interface
- `DIGITS`, 4: number of digit positions scanned (2..8).
- `PRESCALE`, 50000: clock cycles per digit slot (blank + show).
- `BLANK_CYCLES`, 64: anodes-off guard cycles at the start of each slot; 1 ≤ `BLANK_CYCLES` < `PRESCALE`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  scan enable; low forces display dark.
- `value`  in  4*DIGITS  nibble i = digit i, digit 0 rightmost.
- `load`  in  1  capture `value` into pending register this cycle.
- `dp_in`  in  DIGITS  decimal point per digit, active-high request.
- `lz_blank`  in  1  blank leading zero digits (digit 0 never blanked).
- `an`  out  DIGITS  anode selects, active-low.
- `seg`  out  7  segments a..g on bits 0..6, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at end of each full frame.

## Operation
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: `an` all 1, `idx`=0, counter=0. Leave to BLANK the cycle after `en`=1 is sampled.
  - BLANK: `an` all 1 for `BLANK_CYCLES` cycles, then go to SHOW.
  - SHOW: `an[idx]`=0, others 1, for `PRESCALE-BLANK_CYCLES` cycles. Then `idx` ← `idx`+1, wrapping `DIGITS-1`→0, and go to BLANK.
- `en`=0 in any state: next state IDLE, so `an` all 1 on the following cycle. Re-enable always restarts at digit 0 with a full BLANK.
- Value capture is double-buffered:
  - `load` writes `pending` and sets `pend_valid`.
  - The active register is updated only on entry to BLANK for `idx`=0 (frame boundary).
  - If `load` is high in that same cycle, the new `value` goes straight to active and `pend_valid` clears.
  - A second `load` before the boundary overwrites `pending`. Last write wins.
- `seg`/`dp` registers update on entry to BLANK, from the active nibble `idx`. They hold through BLANK and SHOW, so segment changes never occur while an anode is low.
- Leading-zero blank: with `lz_blank`=1, digit i>0 shows `seg`=7'h7F when nibbles i..DIGITS-1 are all zero. `dp` still follows `dp_in[i]`.
- `frame_done` = 1 for exactly the last SHOW cycle of digit `DIGITS-1`.
- Slot counter width = clog2(`PRESCALE`). No overflow is possible; the counter resets at each state change.

## Timing
- Reset values: `an`=all 1, `seg`=7'h7F, `dp`=1, `frame_done`=0, state IDLE, `idx`=0, active/pending = 0, `pend_valid`=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Frame period = `DIGITS`×`PRESCALE` cycles. From `en` sampled high, the first anode goes low after 1+`BLANK_CYCLES` cycles.
- Latency from `load` to display ≤ one frame plus one slot.
- `rst` mid-frame: outputs return to reset values immediately (asynchronous). Pending data is discarded.

## Structure
- Shared package holds:
  - active-low constants `SEG_OFF`=7'h7F and `AN_OFF`;
  - the FSM state enum;
  - the encoding of segment bit order (a=bit0 … g=bit6).
- Sub-module: `hex7_decoder` is the single shared decoder instance, 4-bit in (MSB first), 7-bit active-low out. The scan controller does not re-implement its table.

## Test plan
Bench parameters: `DIGITS`=4, `PRESCALE`=8, `BLANK_CYCLES`=2.

- Reset: assert `rst` mid-SHOW → same cycle `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_done`=0.
- `load` 16'h1234, `en`=1 → digit 0 SHOW: `an`=4'b1110, `seg`=7'h19. Digit 1: `an`=4'b1101, `seg`=7'h30. `frame_done` every 32 cycles. `an` all 1 for exactly 2 cycles between slots.
- `lz_blank`=1, `value`=16'h0008 → digits 3..1 `seg`=7'h7F during SHOW. Digit 0 `seg`=7'h00. `dp_in`=4'b0100 → `dp`=0 only while `an`=4'b1011.
- `load` 16'h8888 during digit 2 SHOW → digits 2,3 keep the old nibbles for the rest of that frame. All four show 7'h00 from the next frame.
- `en` dropped during digit 1 SHOW → `an`=4'b1111 next cycle. Re-raise → 2-cycle BLANK, then `an`=4'b1110.
- `load` asserted on the frame-boundary cycle with 16'h0003 and a stale pending 16'h8888 → the new frame shows 3 on digit 0 (7'h30), never 8.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
// Segment vectors are active-low with a on bit 0 through g on bit 6.
package display_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_SHOW  = 2'd2;

endpackage

// File: rtl/hex7_decoder.sv
// Hex nibble to active-low 7-segment pattern (a = bit 0 .. g = bit 6).
module hex7_decoder
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multi-digit common-anode scan controller: blank guard + show per digit slot,
// double-buffered value capture at frame boundaries, one shared hex decoder.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_active;
  logic [4*DIGITS-1:0] r_pending;
  logic                r_pend_valid;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_frame_done;

  state_t              w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [IDX_W-1:0]    w_idx_next;
  logic                w_blank_entry;
  logic                w_frame_entry;
  logic [4*DIGITS-1:0] w_active_next;
  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_lz;
  logic [6:0]          w_dec_seg;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    if (!en) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_next = ST_SHOW;
            w_cnt_next   = '0;
          end
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_next = ST_BLANK;
            w_cnt_next   = '0;
            w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
      endcase
    end
  end

  // Frame boundary: a same-cycle load bypasses the pending buffer.
  assign w_blank_entry = (w_state_next == ST_BLANK) && (r_state != ST_BLANK);
  assign w_frame_entry = w_blank_entry && (w_idx_next == '0);
  assign w_active_next = !w_frame_entry ? r_active :
                         load           ? value    :
                         r_pend_valid   ? r_pending : r_active;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = w_active_next[4*gi +: 4];
      if (gi == 0) begin : g_units
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz[gi] = (w_active_next[4*DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  hex7_decoder u_dec (
    .i_nibble (w_nib[w_idx_next]),
    .o_seg    (w_dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_an         <= AN_ALL_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      if (w_frame_entry) begin
        r_active     <= w_active_next;
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pending    <= value;
        r_pend_valid <= 1'b1;
      end
      r_an <= (w_state_next == ST_SHOW) ? ~(DIGITS'(1) << w_idx_next) : AN_ALL_OFF;
      // Segments only change while every anode is off.
      if (w_blank_entry) begin
        r_seg <= (lz_blank && w_lz[w_idx_next]) ? SEG_OFF : w_dec_seg;
        r_dp  <= ~dp_in[w_idx_next];
      end
      r_frame_done <= (w_state_next == ST_SHOW) && (w_cnt_next == SHOW_LAST) &&
                      (w_idx_next == IDX_LAST);
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks n_steps cycles of a frame starting just after the edge that
  // begins it; each slot is 2 blank cycles then 6 show cycles.
  task automatic scan_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpx,
                            input int n_steps, input int load_k, input logic [15:0] load_v);
    logic [6:0] sx [4];
    logic [3:0] an_x;
    int d;
    int p;
    sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
    for (int k = 1; k <= n_steps; k++) begin
      if (k == load_k) begin
        value = load_v;
        load  = 1'b1;
      end
      step();
      load = 1'b0;
      d = (k - 1) / 8;
      p = (k - 1) % 8;
      if (p < 2) begin
        chk({name, "_an_blank"}, 32'(an), 32'hF);
      end else begin
        an_x = ~(4'b0001 << d);
        chk({name, "_an"}, 32'(an), 32'(an_x));
        chk({name, "_seg"}, 32'(seg), 32'(sx[d]));
        chk({name, "_dp"}, 32'(dp), 32'(dpx[d]));
      end
      chk({name, "_fd"}, 32'(frame_done), (k == 32) ? 32'd1 : 32'd0);
    end
    $display("frame %s: %0d cycles scanned", name, n_steps);
  endtask

  initial begin
    step();
    step();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_an", 32'(an), 32'hF);

    // Load into pending while idle, then enable: first frame picks it up.
    value = 16'h1234;
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = 16'h0;
    chk("idle_pend_an", 32'(an), 32'hF);
    en = 1'b1;
    scan_frame("f1_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 32, 0, 16'h0);
    scan_frame("f2_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 32, 0, 16'h0);

    lz_blank = 1'b1;
    dp_in    = 4'b0100;
    scan_frame("f3_lzload", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1011, 32, 10, 16'h0008);
    scan_frame("f4_lz0008", 7'h00, 7'h7F, 7'h7F, 7'h7F, 4'b1011, 32, 0, 16'h0);

    lz_blank = 1'b0;
    dp_in    = 4'b0000;
    scan_frame("f5_midload", 7'h00, 7'h40, 7'h40, 7'h40, 4'hF, 32, 20, 16'h8888);
    scan_frame("f6_8888", 7'h00, 7'h00, 7'h00, 7'h00, 4'hF, 32, 5, 16'h8888);
    scan_frame("f7_bndload", 7'h30, 7'h40, 7'h40, 7'h40, 4'hF, 32, 1, 16'h0003);
    scan_frame("f8_0003", 7'h30, 7'h40, 7'h40, 7'h40, 4'hF, 32, 0, 16'h0);

    // Drop enable in the middle of digit 1's show window.
    scan_frame("f9_part", 7'h30, 7'h40, 7'h40, 7'h40, 4'hF, 11, 0, 16'h0);
    en = 1'b0;
    step();
    chk("en_off_an", 32'(an), 32'hF);
    chk("en_off_fd", 32'(frame_done), 32'd0);
    step();
    step();
    chk("en_off_hold_an", 32'(an), 32'hF);
    en = 1'b1;
    scan_frame("f10_reen", 7'h30, 7'h40, 7'h40, 7'h40, 4'hF, 32, 0, 16'h0);

    // Asynchronous reset mid-show with data still pending.
    scan_frame("f11_part", 7'h30, 7'h40, 7'h40, 7'h40, 4'hF, 13, 5, 16'h5555);
    chk("pre_rst_an", 32'(an), 32'hD);
    rst = 1'b1;
    #2;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'd1);
    chk("arst_fd", 32'(frame_done), 32'd0);
    step();
    step();
    rst = 1'b0;
    scan_frame("f12_postrst", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 32, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
